// File: rtl/math_adder_brent_kung_multicycle.sv
// Multi-cycle DATA_WIDTH-bit adder: one shared CHUNK-bit Brent-Kung slice per cycle, LSB chunk first.
// Optional signed-overflow output enabled by defining ADDER_MC_OVERFLOW_EN.
//
// state  | meaning
// S_IDLE | waiting for operands, o_ready high
// S_RUN  | adding chunk cnt through the shared slice
// S_DONE | result held on o_sum/o_carry until i_ready
module math_adder_brent_kung_multicycle #(
  parameter int DATA_WIDTH = 32,
  parameter int CHUNK      = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_c,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_sum,
  output logic                  o_carry,
  output logic                  o_busy
`ifdef ADDER_MC_OVERFLOW_EN
  ,
  output logic                  o_overflow
`endif
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK;
  localparam int CNT_W      = $clog2(NUM_CHUNKS) + 1;
  // largest power of two below CHUNK: first span of the down-sweep
  localparam int DS_TOP     = (1 << $clog2(CHUNK)) >> 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  carry_q;

  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] bit_p;
  logic [CHUNK-1:0] grp_g;
  logic [CHUNK-1:0] grp_p;
  logic [CHUNK:0]   carries;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic             last_chunk;

  assign slice_a    = op_a[int'(cnt)*CHUNK +: CHUNK];
  assign slice_b    = op_b[int'(cnt)*CHUNK +: CHUNK];
  assign last_chunk = (cnt == CNT_W'(NUM_CHUNKS - 1));

  // Brent-Kung prefix: carry-in folded into G[0], so grp_g[i] is the carry into bit i+1
  always_comb begin
    bit_p    = slice_a ^ slice_b;
    grp_g    = slice_a & slice_b;
    grp_p    = bit_p;
    grp_g[0] = grp_g[0] | (bit_p[0] & carry_q);
    for (int d = 1; d < CHUNK; d = d * 2) begin
      for (int i = 2 * d - 1; i < CHUNK; i = i + 2 * d) begin
        grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
        grp_p[i] = grp_p[i] & grp_p[i-d];
      end
    end
    for (int d = DS_TOP; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < CHUNK; i = i + 2 * d) begin
        grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
      end
    end
    carries    = {grp_g, carry_q};
    slice_sum  = bit_p ^ carries[CHUNK-1:0];
    slice_cout = carries[CHUNK];
  end

  assign o_ready = (state == S_IDLE) && i_rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      carry_q    <= 1'b0;
      o_sum      <= '0;
      o_carry    <= 1'b0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
`ifdef ADDER_MC_OVERFLOW_EN
      o_overflow <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            op_a       <= i_a;
            op_b       <= i_b;
            carry_q    <= i_c;
            cnt        <= '0;
            o_busy     <= 1'b1;
            state      <= S_RUN;
`ifdef ADDER_MC_OVERFLOW_EN
            o_overflow <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          o_sum[int'(cnt)*CHUNK +: CHUNK] <= slice_sum;
          carry_q <= slice_cout;
          cnt     <= cnt + CNT_W'(1);
          if (last_chunk) begin
            o_carry    <= slice_cout;
            o_valid    <= 1'b1;
            state      <= S_DONE;
`ifdef ADDER_MC_OVERFLOW_EN
            o_overflow <= carries[CHUNK-1] ^ slice_cout;
`endif
          end
        end
        S_DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_math_adder_brent_kung_multicycle.sv
// Directed-vector bench for math_adder_brent_kung_multicycle (DATA_WIDTH=32, CHUNK=8).
// Overflow checks compile in when ADDER_MC_OVERFLOW_EN is defined.
module tb_math_adder_brent_kung_multicycle;

  localparam int DW  = 32;
  localparam int CH  = 8;
  localparam int LAT = DW / CH;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_a = '0;
  logic [DW-1:0] i_b = '0;
  logic          i_c = 1'b0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [DW-1:0] o_sum;
  logic          o_carry;
  logic          o_busy;
`ifdef ADDER_MC_OVERFLOW_EN
  logic          o_overflow;
`endif

  int n_vec = 0;
  int n_bad = 0;

  math_adder_brent_kung_multicycle #(.DATA_WIDTH(DW), .CHUNK(CH)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_a       (i_a),
    .i_b       (i_b),
    .i_c       (i_c),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_sum     (o_sum),
    .o_carry   (o_carry),
    .o_busy    (o_busy)
`ifdef ADDER_MC_OVERFLOW_EN
    ,
    .o_overflow(o_overflow)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          c;
    logic [DW-1:0] sum;
    logic          carry;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept one operand set, then wait for o_valid; lat = edges from accept to o_valid.
  task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic c,
                          output int lat);
    int t;
    t = 0;
    @(negedge i_clk);
    while (!o_ready && t < 50) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_ready) check("ready_timeout", 64'(o_ready), 64'd1);
    i_a = a;
    i_b = b;
    i_c = c;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_a = $urandom;
    i_b = $urandom;
    i_c = 1'b0;
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result(input int hold);
    repeat (hold) @(posedge i_clk);
    @(negedge i_clk);
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [DW:0] model;

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};
    vecs[5] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 32'hDFD1_0456, 1'b0};
    vecs[7] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0};

    // reset state
    #12;
    check("rst_ready", 64'(o_ready), 64'd0);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_sum",   64'(o_sum),   64'd0);
    check("rst_busy",  64'(o_busy),  64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    check("ready_after_rst", 64'(o_ready), 64'd1);

    for (int v = 0; v < 8; v++) begin
      start_op(vecs[v].a, vecs[v].b, vecs[v].c, lat);
      check($sformatf("v%0d_latency", v), 64'(lat), 64'(LAT));
      check($sformatf("v%0d_sum", v), 64'(o_sum), 64'(vecs[v].sum));
      check($sformatf("v%0d_carry", v), 64'(o_carry), 64'(vecs[v].carry));
      check($sformatf("v%0d_busy", v), 64'(o_busy), 64'd1);
      release_result(0);
      check($sformatf("v%0d_idle", v), 64'({o_valid, o_ready}), 64'b01);
    end

    // result held under back-pressure, new requests ignored
    start_op(32'h00FF_00FF, 32'h0001_0001, 1'b0, lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      i_valid = 1'b1;
      i_a = 32'hAAAA_AAAA;
      i_b = 32'h5555_5555;
      i_c = 1'b1;
      check("hold_valid", 64'(o_valid), 64'd1);
      check("hold_sum",   64'(o_sum),   64'h0100_0100);
      check("hold_carry", 64'(o_carry), 64'd0);
      check("hold_ready", 64'(o_ready), 64'd0);
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    check("bp_release_ready", 64'(o_ready), 64'd1);
    check("bp_release_busy",  64'(o_busy),  64'd0);
    repeat (3) @(posedge i_clk);
    #1;
    check("bp_no_spurious", 64'({o_busy, o_valid}), 64'd0);

    // asynchronous reset after two RUN edges
    @(negedge i_clk);
    i_a = 32'hFFFF_FFFF;
    i_b = 32'h0000_0001;
    i_c = 1'b0;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_sum",   64'(o_sum),   64'd0);
    check("arst_carry", 64'(o_carry), 64'd0);
    check("arst_valid", 64'(o_valid), 64'd0);
    check("arst_busy",  64'(o_busy),  64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0, lat);
    check("post_rst_latency", 64'(lat), 64'(LAT));
    check("post_rst_sum",     64'(o_sum), 64'h2345_6789);
    check("post_rst_carry",   64'(o_carry), 64'd0);
    release_result(0);

`ifdef ADDER_MC_OVERFLOW_EN
    start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
    check("ov_pos_sum", 64'(o_sum), 64'h8000_0000);
    check("ov_pos_flag", 64'(o_overflow), 64'd1);
    release_result(2);
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
    check("ov_wrap_sum", 64'(o_sum), 64'd0);
    check("ov_wrap_carry", 64'(o_carry), 64'd1);
    check("ov_wrap_flag", 64'(o_overflow), 64'd0);
    release_result(0);
`endif

    // random operands with random idle gaps and back-pressure
    for (int r = 0; r < 300; r++) begin
      logic [DW-1:0] ra;
      logic [DW-1:0] rb;
      logic          rc;
      ra = $urandom;
      rb = (r % 4 == 0) ? ~ra : DW'($urandom);
      rc = 1'($urandom_range(0, 1));
      model = {1'b0, ra} + {1'b0, rb} + {{DW{1'b0}}, rc};
      repeat ($urandom_range(0, 2)) @(posedge i_clk);
      start_op(ra, rb, rc, lat);
      check("rnd_latency", 64'(lat), 64'(LAT));
      check("rnd_result", 64'({o_carry, o_sum}), 64'(model));
`ifdef ADDER_MC_OVERFLOW_EN
      check("rnd_overflow", 64'(o_overflow),
            64'((ra[DW-1] == rb[DW-1]) && (model[DW-1] != ra[DW-1])));
`endif
      release_result($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
